// File: rtl/mul_serial_param.sv
// Shift-add serial multiplier, WIDTH-bit operands, 2*WIDTH-bit product.
// Define MUL_SIGNED_EN to add the signed_mode port and the NEG fix-up state.
module mul_serial_param #(
  parameter int WIDTH      = 8,
  parameter int EARLY_TERM = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef MUL_SIGNED_EN
  input  logic               signed_mode,
`endif
  input  logic [WIDTH-1:0]   oper_a,
  input  logic [WIDTH-1:0]   oper_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
`ifdef MUL_SIGNED_EN
    S_NEG,
`endif
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rega_q, rega_d;
  logic [WIDTH-1:0] regb_q, regb_d;
  logic [PW-1:0]   p_q, p_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   res_q, res_d;
  logic            done_q, done_d;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             sm_op;
  logic             last;

`ifdef MUL_SIGNED_EN
  logic sign_q;
  logic sop_q;

  // Operand magnitudes; -2^(WIDTH-1) maps onto unsigned 2^(WIDTH-1)
  always_comb begin
    sm_op = signed_mode;
    mag_a = (signed_mode && oper_a[WIDTH-1]) ? -oper_a : oper_a;
    mag_b = (signed_mode && oper_b[WIDTH-1]) ? -oper_b : oper_b;
  end

  // Latch product sign and signed-op flag on the accepting cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q <= 1'b0;
      sop_q  <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      sign_q <= signed_mode & (oper_a[WIDTH-1] ^ oper_b[WIDTH-1]);
      sop_q  <= signed_mode;
    end
  end
`else
  assign sm_op = 1'b0;
  assign mag_a = oper_a;
  assign mag_b = oper_b;
`endif

  // Final iteration: count hits WIDTH or remaining multiplier exhausted
  assign last = (cnt_q + 1'b1 == CW'(WIDTH)) ||
                ((EARLY_TERM != 0) && ((regb_q >> 1) == '0));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (EARLY_TERM != 0 && oper_b == '0 && !sm_op)
            state_d = S_DONE;
          else
            state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (last) begin
`ifdef MUL_SIGNED_EN
          state_d = sop_q ? S_NEG : S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef MUL_SIGNED_EN
      S_NEG:  state_d = S_DONE;
`endif
      S_DONE: if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: load, shift-add, sign fix-up, result capture
  always_comb begin
    rega_d = rega_q;
    regb_d = regb_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rega_d = PW'(mag_a);
          regb_d = mag_b;
          p_d    = '0;
          cnt_d  = '0;
          if (state_d == S_DONE) res_d = '0;
        end
      end
      S_CALC: begin
        p_d    = regb_q[0] ? p_q + rega_q : p_q;
        rega_d = rega_q << 1;
        regb_d = regb_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (state_d == S_DONE) res_d = p_d;
      end
`ifdef MUL_SIGNED_EN
      S_NEG: begin
        p_d   = sign_q ? -p_q : p_q;
        res_d = p_d;
      end
`endif
      default: ;
    endcase
  end

  assign done_d = (state_d == S_DONE) && (state_q != S_DONE);

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rega_q <= '0;
      regb_q <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      rega_q <= rega_d;
      regb_q <= regb_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
      done_q <= done_d;
    end
  end

  // Outputs
  always_comb begin
`ifdef MUL_SIGNED_EN
    busy = (state_q == S_CALC) || (state_q == S_NEG);
`else
    busy = (state_q == S_CALC);
`endif
    done   = done_q;
    result = res_q;
  end

endmodule

// File: tb/tb_mul_serial_param.sv
// Bench for mul_serial_param: EARLY_TERM=1 and EARLY_TERM=0 side by side,
// checked every cycle against a latency/product model plus literal cases.
module tb_mul_serial_param;
  localparam int W  = 8;
  localparam int PW = 2 * W;
`ifdef MUL_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sm = 1'b0;
  logic [W-1:0] oper_a = '0;
  logic [W-1:0] oper_b = '0;
  logic busy0, done0, busy1, done1;
  logic [PW-1:0] res0, res1;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // model: 0 idle, 1 running, 2 result shown
  int mode [2];
  int done_at [2];
  logic [PW-1:0] pend [2];
  logic [PW-1:0] expr [2];
  int done_cnt [2];
  int last_done [2];

  always #5 clk = ~clk;

  mul_serial_param #(.WIDTH(W), .EARLY_TERM(1)) u_et (
    .clk(clk), .rst(rst), .start(start),
`ifdef MUL_SIGNED_EN
    .signed_mode(sm),
`endif
    .oper_a(oper_a), .oper_b(oper_b),
    .busy(busy0), .done(done0), .result(res0)
  );

  mul_serial_param #(.WIDTH(W), .EARLY_TERM(0)) u_cl (
    .clk(clk), .rst(rst), .start(start),
`ifdef MUL_SIGNED_EN
    .signed_mode(sm),
`endif
    .oper_a(oper_a), .oper_b(oper_b),
    .busy(busy1), .done(done1), .result(res1)
  );

  function automatic int nbits(input logic [W-1:0] v);
    int r = 0;
    for (int i = 0; i < W; i++) if (v[i]) r = i + 1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference model, advanced on each rising edge
  always @(posedge clk) begin
    int n;
    bit s;
    logic [W-1:0] mb;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mode[k] = 0;
        expr[k] = '0;
      end else begin
        case (mode[k])
          0: if (start) begin
            s  = SIGNED_BUILD && sm;
            mb = (s && oper_b[W-1]) ? -oper_b : oper_b;
            n  = (k == 0) ? nbits(mb) : W;
            if (s) begin
              if (n == 0) n = 1;
              n = n + 1;
              pend[k] = PW'(int'($signed(oper_a)) * int'($signed(oper_b)));
            end else begin
              pend[k] = PW'(oper_a) * PW'(oper_b);
            end
            done_at[k] = cyc + n + 1;
            if (n == 0) begin
              mode[k] = 2;
              expr[k] = pend[k];
            end else begin
              mode[k] = 1;
            end
          end
          1: if (cyc + 1 == done_at[k]) begin
            mode[k] = 2;
            expr[k] = pend[k];
          end
          default: if (!start) mode[k] = 0;
        endcase
      end
    end
    cyc++;
  end

  // Per-cycle comparison of both DUTs against the model
  always @(negedge clk) begin
    logic b, d;
    logic [PW-1:0] r;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        b = (k == 0) ? busy0 : busy1;
        d = (k == 0) ? done0 : done1;
        r = (k == 0) ? res0 : res1;
        check($sformatf("busy%0d", k), 32'(b), 32'(mode[k] == 1));
        check($sformatf("done%0d", k), 32'(d),
              32'(mode[k] == 2 && cyc == done_at[k]));
        check($sformatf("result%0d", k), 32'(r), 32'(expr[k]));
        if (d === 1'b1) begin
          done_cnt[k]++;
          last_done[k] = cyc;
        end
      end
    end
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 64; i++) begin
      if (mode[0] == 0 && mode[1] == 0) break;
      @(posedge clk); #1;
    end
    if (i == 64) check("idle_timeout", 32'(i), 32'(0));
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                    input int hold, input bit s, input bit scramble,
                    output int c0);
    start = 1'b1;
    oper_a = a;
    oper_b = b;
    sm = s;
    c0 = cyc;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (scramble) begin
        oper_a = W'($urandom);
        oper_b = W'($urandom);
        sm = SIGNED_BUILD & bit'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    int c0, n0;
    logic [W-1:0] ra, rb;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_busy", 32'(busy0), 32'(0));
    check("rst_result", 32'(res0), 32'(0));
    rst = 1'b0;

    op(8'd13, 8'd11, 1, 1'b0, 1'b0, c0);
    check("t13x11_lat_et", 32'(last_done[0] - c0), 32'd5);
    check("t13x11_res_et", 32'(res0), 32'h008F);
    check("t13x11_lat_cl", 32'(last_done[1] - c0), 32'd9);
    check("t13x11_res_cl", 32'(res1), 32'h008F);

    op(8'd255, 8'd255, 1, 1'b0, 1'b0, c0);
    check("t255sq_lat", 32'(last_done[0] - c0), 32'd9);
    check("t255sq_res", 32'(res0), 32'hFE01);

    op(8'd255, 8'd1, 1, 1'b0, 1'b0, c0);
    check("tb1_lat_cl", 32'(last_done[1] - c0), 32'd9);
    check("tb1_res_cl", 32'(res1), 32'h00FF);
    check("tb1_lat_et", 32'(last_done[0] - c0), 32'd2);

    n0 = done_cnt[0];
    op(8'd200, 8'd0, 20, 1'b0, 1'b0, c0);
    check("tb0_lat", 32'(last_done[0] - c0), 32'd1);
    check("tb0_res", 32'(res0), 32'd0);
    check("tb0_one_pulse", 32'(done_cnt[0] - n0), 32'd1);

    n0 = done_cnt[0];
    start = 1'b1; oper_a = 8'd13; oper_b = 8'd11; c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; oper_a = 8'd99; oper_b = 8'd77;
    @(posedge clk); #1;
    start = 1'b0; oper_a = 8'd1;
    wait_idle();
    check("tmid_res", 32'(res0), 32'd143);
    check("tmid_lat", 32'(last_done[0] - c0), 32'd5);
    check("tmid_pulses", 32'(done_cnt[0] - n0), 32'd1);

    start = 1'b1; oper_a = 8'd255; oper_b = 8'd255;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("trst_busy", 32'(busy0), 32'd0);
    check("trst_done", 32'(done0), 32'd0);
    check("trst_res", 32'(res0), 32'd0);
    rst = 1'b0;
    op(8'd3, 8'd5, 1, 1'b0, 1'b0, c0);
    check("trst_3x5", 32'(res0), 32'd15);
    n0 = last_done[0] - c0;

`ifdef MUL_SIGNED_EN
    op(8'h80, 8'h80, 1, 1'b1, 1'b0, c0);
    check("ts_min_sq", 32'(res0), 32'h4000);
    op(8'hFD, 8'd5, 1, 1'b1, 1'b0, c0);
    check("ts_m3x5", 32'(res0), 32'hFFF1);
    check("ts_m3x5_lat", 32'(last_done[0] - c0), 32'(n0 + 1));
    op(8'hFD, 8'd5, 1, 1'b0, 1'b0, c0);
    check("ts_uns", 32'(res0), 32'h04F1);
`endif

    for (int t = 0; t < 300; t++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = W'(1 << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      op(ra, rb, $urandom_range(1, 6),
         SIGNED_BUILD & bit'($urandom_range(0, 1)), 1'b1, c0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
